// File: rtl/prco_lsu_wb.sv
// prco_lsu_wb: load/store and writeback stage of the PRCO core.
// It takes the ALU's registered result and does one of three things:
// a register-file write, a handshaked RAM load/store, or a PC redirect.
// A one-cycle q_done marks commit. q_busy holds off issue while a RAM
// access is outstanding.
module prco_lsu_wb #(
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce_reg,
  input  logic              i_ce_ram,
  input  logic              i_should_branch,
  input  logic [4:0]        i_op,
  input  logic [15:0]       i_result,
  input  logic [15:0]       i_store_data,
  input  logic [REG_AW-1:0] i_rd,
  output logic              q_ram_req,
  output logic              q_ram_we,
  output logic [15:0]       q_ram_addr,
  output logic [15:0]       q_ram_wdata,
  input  logic              i_ram_ack,
  input  logic [15:0]       i_ram_rdata,
  output logic              q_reg_we,
  output logic [REG_AW-1:0] q_reg_waddr,
  output logic [15:0]       q_reg_wdata,
  output logic              q_pc_load,
  output logic [15:0]       q_pc_target,
  output logic              q_done,
  output logic              q_busy,
  output logic              q_err
);

  // Opcode encodings shared with the decoder.
  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_CMP   = 5'h03;
  localparam logic [4:0] OP_LW    = 5'h08;
  localparam logic [4:0] OP_SW    = 5'h09;
  localparam logic [4:0] OP_JMP   = 5'h0A;
  localparam logic [4:0] OP_WRITE = 5'h0B;

  // The counter counts waiting edges after the request was raised.
  // Expiry at TIMEOUT-1 keeps the request up for exactly TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_MEM
  } state_t;

  state_t             state;
  logic [7:0]         count;
  logic [REG_AW-1:0]  mem_rd;
  logic               no_wb;

  // These opcodes commit without writing the register file.
  always_comb begin
    no_wb = (i_op == OP_CMP) || (i_op == OP_NOP) || (i_op == OP_WRITE);
  end

  assign q_busy = (state == S_MEM);

  // Sequencing of the register/branch path and the RAM handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      mem_rd      <= '0;
      q_ram_req   <= 1'b0;
      q_ram_we    <= 1'b0;
      q_ram_addr  <= '0;
      q_ram_wdata <= '0;
      q_reg_we    <= 1'b0;
      q_reg_waddr <= '0;
      q_reg_wdata <= '0;
      q_pc_load   <= 1'b0;
      q_pc_target <= '0;
      q_done      <= 1'b0;
      q_err       <= 1'b0;
    end else begin
      q_reg_we  <= 1'b0;
      q_pc_load <= 1'b0;
      q_done    <= 1'b0;
      if (state == S_IDLE) begin
        if (i_ce_ram) begin
          // RAM path has priority over a simultaneous register-path enable.
          q_ram_addr  <= i_result;
          q_ram_wdata <= i_store_data;
          q_ram_we    <= (i_op == OP_SW);
          mem_rd      <= i_rd;
          q_ram_req   <= 1'b1;
          count       <= '0;
          state       <= S_MEM;
          if (i_ce_reg) begin
            q_err <= 1'b1;
          end
        end else if (i_ce_reg) begin
          q_done <= 1'b1;
          if (i_op == OP_JMP) begin
            if (i_should_branch) begin
              q_pc_load   <= 1'b1;
              q_pc_target <= i_result;
            end
          end else if (!no_wb) begin
            q_reg_we    <= 1'b1;
            q_reg_waddr <= i_rd;
            q_reg_wdata <= i_result;
          end
        end
      end else begin
        if (i_ce_reg || i_ce_ram) begin
          q_err <= 1'b1;
        end
        if (i_ram_ack) begin
          q_ram_req <= 1'b0;
          q_done    <= 1'b1;
          state     <= S_IDLE;
          if (!q_ram_we) begin
            q_reg_we    <= 1'b1;
            q_reg_waddr <= mem_rd;
            q_reg_wdata <= i_ram_rdata;
          end
        end else if (count == CNT_LAST) begin
          q_ram_req <= 1'b0;
          q_done    <= 1'b1;
          q_err     <= 1'b1;
          state     <= S_IDLE;
        end else begin
          count <= count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prco_lsu_wb.sv
// Self-checking bench for prco_lsu_wb. It uses a directed table for the
// register/branch path, hand-written RAM and reset sequences, and a
// randomized instruction stream. Expected outputs come from a
// transaction-level model kept in this bench.
module tb_prco_lsu_wb;

  localparam int unsigned TO = 8;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_CMP   = 5'h03;
  localparam logic [4:0] OP_LW    = 5'h08;
  localparam logic [4:0] OP_SW    = 5'h09;
  localparam logic [4:0] OP_JMP   = 5'h0A;
  localparam logic [4:0] OP_WRITE = 5'h0B;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ce_reg, i_ce_ram, i_should_branch, i_ram_ack;
  logic [4:0]  i_op;
  logic [15:0] i_result, i_store_data, i_ram_rdata;
  logic [2:0]  i_rd;
  logic        q_ram_req, q_ram_we, q_reg_we, q_pc_load, q_done, q_busy, q_err;
  logic [15:0] q_ram_addr, q_ram_wdata, q_reg_wdata, q_pc_target;
  logic [2:0]  q_reg_waddr;

  prco_lsu_wb #(.REG_AW(3), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce_reg(i_ce_reg), .i_ce_ram(i_ce_ram),
    .i_should_branch(i_should_branch), .i_op(i_op), .i_result(i_result),
    .i_store_data(i_store_data), .i_rd(i_rd), .q_ram_req(q_ram_req),
    .q_ram_we(q_ram_we), .q_ram_addr(q_ram_addr), .q_ram_wdata(q_ram_wdata),
    .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata), .q_reg_we(q_reg_we),
    .q_reg_waddr(q_reg_waddr), .q_reg_wdata(q_reg_wdata), .q_pc_load(q_pc_load),
    .q_pc_target(q_pc_target), .q_done(q_done), .q_busy(q_busy), .q_err(q_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Expected architectural view of the outputs.
  logic        e_req, e_we, e_reg_we, e_pc, e_done, e_busy, e_err;
  logic [15:0] e_addr, e_wdata, e_rwdata, e_target;
  logic [2:0]  e_waddr;

  typedef struct {
    logic        ce_reg;
    logic        br;
    logic [4:0]  op;
    logic [15:0] res;
    logic [2:0]  rd;
    logic        x_we;
    logic        x_pc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},     32'(q_ram_req),   32'(e_req));
    chk({tag, ".we"},      32'(q_ram_we),    32'(e_we));
    chk({tag, ".addr"},    32'(q_ram_addr),  32'(e_addr));
    chk({tag, ".wdata"},   32'(q_ram_wdata), 32'(e_wdata));
    chk({tag, ".reg_we"},  32'(q_reg_we),    32'(e_reg_we));
    chk({tag, ".waddr"},   32'(q_reg_waddr), 32'(e_waddr));
    chk({tag, ".rwdata"},  32'(q_reg_wdata), 32'(e_rwdata));
    chk({tag, ".pc_load"}, 32'(q_pc_load),   32'(e_pc));
    chk({tag, ".target"},  32'(q_pc_target), 32'(e_target));
    chk({tag, ".done"},    32'(q_done),      32'(e_done));
    chk({tag, ".busy"},    32'(q_busy),      32'(e_busy));
    chk({tag, ".err"},     32'(q_err),       32'(e_err));
  endtask

  task automatic model_reset();
    e_req = 0; e_we = 0; e_reg_we = 0; e_pc = 0; e_done = 0; e_busy = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_rwdata = '0; e_target = '0; e_waddr = '0;
  endtask

  task automatic clr_strobes();
    e_reg_we = 0; e_pc = 0; e_done = 0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ce_reg = 0; i_ce_ram = 0; i_should_branch = 0; i_ram_ack = 0;
  endtask

  // Register/branch instruction: effect follows from the opcode class.
  task automatic do_reg(input logic [4:0] op, input logic br,
                        input logic [15:0] res, input logic [2:0] rd);
    i_ce_reg = 1; i_op = op; i_should_branch = br; i_result = res; i_rd = rd;
    i_store_data = 16'($urandom);
    step();
    idle_inputs();
    clr_strobes();
    e_done = 1;
    if (op == OP_JMP) begin
      if (br) begin e_pc = 1; e_target = res; end
    end else if (!(op == OP_CMP || op == OP_NOP || op == OP_WRITE)) begin
      e_reg_we = 1; e_waddr = rd; e_rwdata = res;
    end
    check_all("reg");
  endtask

  // RAM instruction. The ack arrives 'delay' cycles after the request;
  // a delay beyond TO means none arrives in time. 'inject' > 0 raises a
  // stray ce_reg on that wait cycle. 'both' also raises ce_reg at issue.
  task automatic do_mem(input logic [4:0] op, input logic [15:0] addr,
                        input logic [15:0] sd, input logic [2:0] rd,
                        input logic [15:0] rdv, input int delay,
                        input int inject, input logic both);
    i_ce_ram = 1; i_ce_reg = both; i_op = op; i_result = addr;
    i_store_data = sd; i_rd = rd;
    step();
    idle_inputs();
    clr_strobes();
    e_req = 1; e_busy = 1; e_we = (op == OP_SW); e_addr = addr; e_wdata = sd;
    if (both) e_err = 1;
    check_all("mem_issue");
    for (int j = 1; j <= int'(TO); j++) begin
      i_ram_ack = (j == delay);
      i_ram_rdata = (j == delay) ? rdv : 16'($urandom);
      if (j == inject) begin
        i_ce_reg = 1; i_op = OP_ADD; i_rd = 3'($urandom); i_result = 16'($urandom);
        e_err = 1;
      end
      step();
      idle_inputs();
      clr_strobes();
      if (j == delay) begin
        e_req = 0; e_busy = 0; e_done = 1;
        if (!e_we) begin e_reg_we = 1; e_waddr = rd; e_rwdata = rdv; end
        check_all("mem_ack");
        break;
      end else if (j == int'(TO)) begin
        e_req = 0; e_busy = 0; e_done = 1; e_err = 1;
        check_all("mem_timeout");
      end else begin
        check_all("mem_wait");
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 0, OP_ADD,   16'h1234, 3'd3, 1, 0};
    tbl[1] = '{1, 1, OP_JMP,   16'h0040, 3'd1, 0, 1};
    tbl[2] = '{1, 0, OP_JMP,   16'h0080, 3'd2, 0, 0};
    tbl[3] = '{1, 1, OP_CMP,   16'h5555, 3'd4, 0, 0};
    tbl[4] = '{1, 0, OP_NOP,   16'h6666, 3'd5, 0, 0};
    tbl[5] = '{1, 0, OP_WRITE, 16'h7777, 3'd6, 0, 0};
    tbl[6] = '{1, 1, OP_SUB,   16'hFFFF, 3'd7, 1, 0};
    tbl[7] = '{0, 1, OP_ADD,   16'hAAAA, 3'd2, 0, 0};

    idle_inputs();
    i_op = OP_NOP; i_result = '0; i_store_data = '0; i_rd = '0; i_ram_rdata = '0;
    i_rst_n = 0;
    model_reset();
    #12;
    check_all("reset");
    i_rst_n = 1;
    step();
    check_all("post_reset");

    // Directed register/branch vectors, each followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      i_ce_reg = tbl[i].ce_reg; i_should_branch = tbl[i].br; i_op = tbl[i].op;
      i_result = tbl[i].res; i_rd = tbl[i].rd;
      step();
      idle_inputs();
      clr_strobes();
      e_done = tbl[i].ce_reg;
      if (tbl[i].x_we) begin e_reg_we = 1; e_waddr = tbl[i].rd; e_rwdata = tbl[i].res; end
      if (tbl[i].x_pc) begin e_pc = 1; e_target = tbl[i].res; end
      check_all($sformatf("vec%0d", i));
      step();
      clr_strobes();
      check_all($sformatf("vec%0d_idle", i));
    end

    // LW with ack after 3 cycles, then SW with ack after 1 cycle.
    do_mem(OP_LW, 16'h0010, 16'h0000, 3'd5, 16'hBEEF, 3, 0, 0);
    do_mem(OP_SW, 16'h0020, 16'h00AA, 3'd2, 16'h1111, 1, 0, 0);
    step(); clr_strobes(); check_all("sw_idle");

    // Ack on the last allowed cycle takes priority over expiry.
    do_mem(OP_LW, 16'h0030, 16'h0000, 3'd1, 16'h4321, int'(TO), 0, 0);
    chk("late_ack_no_err", 32'(q_err), 32'(0));

    // Timeout: no ack. The error must stay set afterwards.
    do_mem(OP_LW, 16'h0044, 16'h0000, 3'd6, 16'h0000, 100, 0, 0);
    step(); clr_strobes(); check_all("timeout_idle");
    do_reg(OP_ADD, 0, 16'h0F0F, 3'd2);
    chk("err_sticky", 32'(q_err), 32'(1));

    // Reset mid-MEM drops everything asynchronously.
    i_ce_ram = 1; i_op = OP_LW; i_result = 16'h0099; i_rd = 3'd4;
    step();
    idle_inputs();
    chk("pre_rst.req", 32'(q_ram_req), 32'(1));
    #2 i_rst_n = 0;
    #1;
    model_reset();
    check_all("async_reset");
    #2 i_rst_n = 1;
    i_ram_ack = 1; i_ram_rdata = 16'hDEAD;
    step();
    i_ram_ack = 0;
    check_all("stray_ack");

    // Simultaneous ce_reg/ce_ram: the RAM path wins and an error is flagged.
    do_mem(OP_SW, 16'h0100, 16'h0BAD, 3'd3, 16'h0000, 2, 0, 1);
    // Injecting ce during MEM is dropped and flags an error.
    i_rst_n = 0; #1; model_reset(); i_rst_n = 1;
    do_mem(OP_LW, 16'h0200, 16'h0000, 3'd7, 16'hCAFE, 4, 2, 0);
    step(); clr_strobes(); check_all("inject_idle");

    // Random instruction stream, back-to-back without idle cycles.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      if (kind < 6) begin
        logic [4:0] ops [7];
        ops = '{OP_NOP, OP_ADD, OP_SUB, OP_CMP, OP_JMP, OP_WRITE, 5'h05};
        do_reg(ops[$urandom_range(0, 6)], 1'($urandom), 16'($urandom), 3'($urandom));
      end else begin
        do_mem(($urandom_range(0, 1) != 0) ? OP_SW : OP_LW, 16'($urandom),
               16'($urandom), 3'($urandom), 16'($urandom),
               int'($urandom_range(1, TO + 2)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
               1'($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 3) == 0) begin
        step(); clr_strobes(); check_all("rand_idle");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
